// File: rtl/apb_xfer_engine.sv
// APB3 master transfer engine: runs one SETUP/ACCESS transfer per command and
// returns read data or failure status as a single-cycle response strobe.
module apb_xfer_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int SLV_ID_WIDTH = 7,
  parameter int TOTAL_SLAVE  = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [SLV_ID_WIDTH-1:0] cmd_slv_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_en,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [SLV_ID_WIDTH-1:0] rsp_id,
  output logic                    rsp_write,
  output logic [1:0]              rsp_status,
  input  logic                    rsp_full,
  output logic                    pclk,
  output logic [TOTAL_SLAVE-1:0]  psel,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic                    penable,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_SLVERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_DECERR  = 2'b11;

  // A zero TIMEOUT still needs a 1-bit counter so the width never collapses.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SLV_ID_WIDTH:0] NUM_SLV = (SLV_ID_WIDTH + 1)'(TOTAL_SLAVE);

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next, w_cnt_inc;
  logic [TOTAL_SLAVE-1:0]  r_psel, w_psel_next, w_sel_onehot;
  logic                    r_penable, w_penable_next;
  logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr_next;
  logic                    r_pwrite, w_pwrite_next;
  logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata_next;
  logic                    r_rsp_en, w_rsp_en_next;
  logic [DATA_WIDTH-1:0]   r_rsp_data, w_rsp_data_next;
  logic [SLV_ID_WIDTH-1:0] r_rsp_id, w_rsp_id_next;
  logic                    r_rsp_write, w_rsp_write_next;
  logic [1:0]              r_rsp_status, w_rsp_status_next;
  logic                    w_id_valid;
  logic                    w_timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < TOTAL_SLAVE; gi++) begin : g_sel
      assign w_sel_onehot[gi] = (cmd_slv_id == SLV_ID_WIDTH'(gi));
    end
  endgenerate

  assign w_id_valid    = ({1'b0, cmd_slv_id} < NUM_SLV);
  // Saturating increment: the counter may stick at its maximum but never wraps.
  assign w_cnt_inc     = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout_hit = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_psel_next       = r_psel;
    w_penable_next    = r_penable;
    w_paddr_next      = r_paddr;
    w_pwrite_next     = r_pwrite;
    w_pwdata_next     = r_pwdata;
    w_rsp_en_next     = 1'b0;
    w_rsp_data_next   = r_rsp_data;
    w_rsp_id_next     = r_rsp_id;
    w_rsp_write_next  = r_rsp_write;
    w_rsp_status_next = r_rsp_status;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_paddr_next      = cmd_addr;
          w_pwrite_next     = cmd_write;
          w_pwdata_next     = cmd_wdata;
          w_rsp_id_next     = cmd_slv_id;
          w_rsp_write_next  = cmd_write;
          w_rsp_data_next   = '0;
          w_cnt_next        = '0;
          if (w_id_valid) begin
            w_psel_next       = w_sel_onehot;
            w_rsp_status_next = ST_OK;
            w_state_next      = S_SETUP;
          end else begin
            w_rsp_status_next = ST_DECERR;
            w_rsp_en_next     = ~rsp_full;
            w_state_next      = S_RESP;
          end
        end
      end

      S_SETUP: begin
        w_penable_next = 1'b1;
        w_state_next   = S_ACCESS;
      end

      S_ACCESS: begin
        if (pready) begin
          w_psel_next    = '0;
          w_penable_next = 1'b0;
          if (!r_pwrite || pslverr) begin
            w_rsp_status_next = pslverr ? ST_SLVERR : ST_OK;
            w_rsp_data_next   = (!r_pwrite && !pslverr) ? prdata : '0;
            w_rsp_en_next     = ~rsp_full;
            w_state_next      = S_RESP;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_timeout_hit) begin
            w_psel_next       = '0;
            w_penable_next    = 1'b0;
            w_rsp_status_next = ST_TIMEOUT;
            w_rsp_data_next   = '0;
            w_state_next      = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (r_rsp_en) begin
          w_state_next = S_IDLE;
        end else begin
          w_rsp_en_next = ~rsp_full;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_psel       <= '0;
      r_penable    <= 1'b0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_rsp_en     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
      r_rsp_write  <= 1'b0;
      r_rsp_status <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_psel       <= w_psel_next;
      r_penable    <= w_penable_next;
      r_paddr      <= w_paddr_next;
      r_pwrite     <= w_pwrite_next;
      r_pwdata     <= w_pwdata_next;
      r_rsp_en     <= w_rsp_en_next;
      r_rsp_data   <= w_rsp_data_next;
      r_rsp_id     <= w_rsp_id_next;
      r_rsp_write  <= w_rsp_write_next;
      r_rsp_status <= w_rsp_status_next;
    end
  end

  assign pclk       = clk;
  assign cmd_ready  = (r_state == S_IDLE);
  assign psel       = r_psel;
  assign penable    = r_penable;
  assign paddr      = r_paddr;
  assign pwrite     = r_pwrite;
  assign pwdata     = r_pwdata;
  assign rsp_en     = r_rsp_en;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;
  assign rsp_write  = r_rsp_write;
  assign rsp_status = r_rsp_status;

endmodule

// File: tb/tb_apb_xfer_engine.sv
// Scoreboard bench for apb_xfer_engine: directed commands against a small
// APB slave model with programmable wait states.
module tb_apb_xfer_engine;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int IW = 7;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [IW-1:0] cmd_slv_id = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_en;
  logic [DW-1:0] rsp_data;
  logic [IW-1:0] rsp_id;
  logic          rsp_write;
  logic [1:0]    rsp_status;
  logic          rsp_full = 1'b0;
  logic          pclk;
  logic [NS-1:0] psel;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  int wait_n  = 0;
  int acc_cnt = 0;
  int errors  = 0;
  int checks  = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          wr;
    logic [1:0]    status;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  apb_xfer_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLV_ID_WIDTH(IW),
    .TOTAL_SLAVE(NS), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_slv_id(cmd_slv_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_en(rsp_en), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_write(rsp_write), .rsp_status(rsp_status), .rsp_full(rsp_full),
    .pclk(pclk), .psel(psel), .paddr(paddr), .pwrite(pwrite),
    .penable(penable), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Slave model: pready rises after wait_n ACCESS cycles.
  always @(posedge clk) begin
    if ((psel != '0) && penable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready = (psel != '0) && penable && (acc_cnt == wait_n);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rsp_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d wr=%0b st=%0d data=0x%0h, none expected",
                 rsp_id, rsp_write, rsp_status, rsp_data);
      end else begin
        rsp_t e;
        rsp_t a;
        e = exp_q.pop_front();
        a = '{id: rsp_id, wr: rsp_write, status: rsp_status, data: rsp_data};
        if (a !== e) begin
          errors++;
          $display("FAIL rsp_fields: got id=%0d wr=%0b st=%0d data=0x%0h expected id=%0d wr=%0b st=%0d data=0x%0h",
                   a.id, a.wr, a.status, a.data, e.id, e.wr, e.status, e.data);
        end else begin
          $display("rsp id=%0d wr=%0b st=%0d data=0x%0h ok", a.id, a.wr, a.status, a.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command in cycle T and returns at T+1 with cmd_valid dropped.
  task automatic issue(input logic wr, input int id, input int addr, input int wdata);
    chk("cmd_ready_at_T", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_slv_id = IW'(id);
    cmd_addr   = AW'(addr);
    cmd_wdata  = DW'(wdata);
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Runs until the engine is idle again, counting ACCESS cycles.
  task automatic wait_idle(input string name, output int acc_cycles);
    int n;
    acc_cycles = 0;
    n = 0;
    while (!cmd_ready && n < 40) begin
      if (penable) acc_cycles++;
      tick();
      n++;
    end
    chk(name, cmd_ready, 1);
  endtask

  initial begin
    int acc;
    tick();
    chk("reset_psel", psel, 0);
    chk("reset_penable", penable, 0);
    chk("reset_rsp_en", rsp_en, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_rsp_status", rsp_status, 0);
    rst = 1'b0;
    tick();

    // Zero-wait write to slave 2: no response expected.
    wait_n = 0;
    issue(1'b1, 2, 'h34, 'hBEEF);
    chk("wr_psel_T1", psel, 4'b0100);
    chk("wr_penable_T1", penable, 0);
    chk("wr_paddr", paddr, 'h34);
    chk("wr_pwdata", pwdata, 'hBEEF);
    chk("wr_pwrite", pwrite, 1);
    tick();
    chk("wr_psel_T2", psel, 4'b0100);
    chk("wr_penable_T2", penable, 1);
    tick();
    chk("wr_psel_T3", psel, 0);
    chk("wr_penable_T3", penable, 0);
    chk("wr_cmd_ready_T3", cmd_ready, 1);
    chk("wr_rsp_en_T3", rsp_en, 0);

    // Read slave 0 with 3 wait states.
    wait_n = 3;
    prdata = 'h1234;
    exp_q.push_back('{id: 0, wr: 1'b0, status: 2'b00, data: 16'h1234});
    issue(1'b0, 0, 'h10, 0);
    for (int i = 2; i <= 6; i++) begin
      tick();
      if (i == 5) chk("rd_no_rsp_T5", rsp_en, 0);
    end
    chk("rd_rsp_en_T6", rsp_en, 1);
    tick();
    chk("rd_idle_T7", cmd_ready, 1);

    // Read with slave error while the consumer is full for 5 cycles.
    wait_n   = 0;
    pslverr  = 1'b1;
    prdata   = 'hAAAA;
    rsp_full = 1'b1;
    exp_q.push_back('{id: 1, wr: 1'b0, status: 2'b01, data: 16'h0000});
    issue(1'b0, 1, 'h22, 0);
    tick();
    tick();
    pslverr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("full_no_strobe", rsp_en, 0);
      chk("full_status_held", rsp_status, 2'b01);
      chk("full_data_held", rsp_data, 0);
      tick();
    end
    rsp_full = 1'b0;
    wait_idle("full_release_idle", acc);

    // Write with slave error returns SLVERR.
    pslverr = 1'b1;
    exp_q.push_back('{id: 1, wr: 1'b1, status: 2'b01, data: 16'h0000});
    issue(1'b1, 1, 'h40, 'h0F0F);
    wait_idle("wr_slverr_idle", acc);
    pslverr = 1'b0;

    // Timeout: pready stuck low.
    wait_n = 100;
    exp_q.push_back('{id: 3, wr: 1'b0, status: 2'b10, data: 16'h0000});
    issue(1'b0, 3, 'h55, 0);
    wait_idle("to_idle", acc);
    chk("to_access_cycles", acc, 4);

    // pready rises on the 4th ACCESS cycle: completion wins.
    wait_n = 3;
    prdata = 'h5A5A;
    exp_q.push_back('{id: 3, wr: 1'b0, status: 2'b00, data: 16'h5A5A});
    issue(1'b0, 3, 'h56, 0);
    wait_idle("to_edge_idle", acc);
    chk("to_edge_access_cycles", acc, 4);

    // Decode error on an out-of-range slave id.
    exp_q.push_back('{id: 9, wr: 1'b1, status: 2'b11, data: 16'h0000});
    issue(1'b1, 9, 'h01, 'h1111);
    chk("dec_rsp_en_T1", rsp_en, 1);
    chk("dec_psel_T1", psel, 0);
    tick();
    chk("dec_psel_T2", psel, 0);
    wait_idle("dec_idle", acc);

    // Reset during ACCESS drops the bus and loses the command.
    wait_n = 100;
    issue(1'b0, 1, 'h77, 0);
    tick();
    chk("rst_penable_before", penable, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_psel_now", psel, 0);
    chk("rst_penable_now", penable, 0);
    chk("rst_rsp_en_now", rsp_en, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready_after", cmd_ready, 1);
    for (int i = 0; i < 4; i++) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_xfer_engine.md
# apb_xfer_engine

Protocol-level APB master stage downstream of `apb_data_controller`. It accepts one decoded command at a time (slave id, address, write data, direction) and runs a compliant APB3 SETUP/ACCESS transfer on the selected slave. It handles wait states, slave error and timeout, and decode errors. Read results and write failures are returned as single-cycle responses toward the `pp_rd_fifo` path, with backpressure.

## Interface

Parameters:
- DATA_WIDTH, 16: pwdata/prdata/rsp_data width.
- ADDR_WIDTH, 8: paddr width.
- SLV_ID_WIDTH, 7: slave id width.
- TOTAL_SLAVE, 4: number of psel lines.
- TIMEOUT, 255: number of consecutive ACCESS cycles with pready low before abort. 0 disables the timeout.

Ports:
- clk  in  1  dt_clk domain clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_slv_id  in  SLV_ID_WIDTH  target slave index.
- cmd_addr  in  ADDR_WIDTH  register address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_en  out  1  one-cycle response strobe.
- rsp_data  out  DATA_WIDTH  read data; 0 unless status OK on a read.
- rsp_id  out  SLV_ID_WIDTH  slave id of the command.
- rsp_write  out  1  direction of the command.
- rsp_status  out  2  00 OK, 01 SLVERR, 10 TIMEOUT, 11 DECERR.
- rsp_full  in  1  consumer full; blocks rsp_en.
- pclk  out  1  equal to clk.
- psel  out  TOTAL_SLAVE  one-hot select.
- paddr  out  ADDR_WIDTH.
- pwrite  out  1.
- penable  out  1.
- pwdata  out  DATA_WIDTH.
- pready  in  1.
- prdata  in  DATA_WIDTH.
- pslverr  in  1.

## Operation

- States: IDLE, SETUP, ACCESS, RESP. All outputs except pclk and cmd_ready are registered.
- Reset: every output is 0, state is IDLE, timeout counter is 0. Reset takes effect immediately (asynchronous).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_* into paddr/pwrite/pwdata and into the response id/write registers.
  - If cmd_slv_id < TOTAL_SLAVE: psel[cmd_slv_id]=1, next state SETUP.
  - Otherwise: no APB activity, status=DECERR, next state RESP. This applies to both reads and writes.
- SETUP: psel held, penable=0. Always go to ACCESS.
- ACCESS: penable=1; psel, paddr, pwrite and pwdata are stable.
  - pready=1: capture prdata (reads only) and pslverr, clear psel/penable.
    - Read → RESP.
    - Write with pslverr=1 → RESP with SLVERR.
    - Write OK → IDLE; no response is generated.
  - pready=0: increment the counter. If the counter reaches TIMEOUT (TIMEOUT≠0), clear psel/penable, set status=TIMEOUT and rsp_data=0, go to RESP.
- RESP:
  - rsp_full=0: rsp_en=1 for exactly one cycle, then IDLE.
  - rsp_full=1: hold all rsp_* fields, no strobe.
- Status priority on completion: pready=1 wins over timeout in the same cycle. pslverr on a read gives SLVERR with rsp_data=0.
- Timeout counter width is $clog2(TIMEOUT+1). It clears on entry to SETUP and saturates; it never wraps.
- paddr/pwrite/pwdata keep their last values after a transfer. psel and penable are 0 outside SETUP/ACCESS.
- Reset mid-transfer: the bus is dropped immediately, no response is generated, and the command is lost.

## Timing

- Command accepted in cycle T, zero-wait slave:
  - T+1: SETUP.
  - T+2: ACCESS with pready=1.
  - Write: IDLE at T+3, cmd_ready=1 at T+3.
  - Read: rsp_en at T+3, IDLE at T+4.
- N wait states: completion moves later by N cycles.
- Timeout: with pready held low, the abort happens at ACCESS cycle number TIMEOUT. psel drops the next cycle, and rsp_en follows one cycle later if rsp_full=0.
- DECERR: rsp_en at T+1.
- Back-to-back commands have at least one IDLE cycle between transfers. penable never stays high across two transfers.

## Test plan

- Write: slv_id=2, addr=0x34, wdata=0xBEEF, zero-wait → psel=4'b0100 at T+1..T+2, penable only at T+2, no rsp_en, cmd_ready at T+3.
- Read: slv_id=0, addr=0x10, prdata=0x1234 after 3 wait states → rsp_en once at T+6 with rsp_data=0x1234, status 00, rsp_id=0, rsp_write=0.
- Read with pslverr=1, rsp_full held high for 5 cycles → rsp_* stable and no strobe while full; one rsp_en after release with status 01, rsp_data=0.
- TIMEOUT=4, pready stuck low → abort after 4 ACCESS cycles, rsp_en with status 10. Repeat with pready rising on the 4th cycle → status 00.
- cmd_slv_id=9 (≥ TOTAL_SLAVE) write → psel stays 0 throughout, rsp_en at T+1 with status 11, rsp_write=1.
- Assert rst during ACCESS → psel, penable and rsp_en go to 0 in the same cycle, cmd_ready=1 after release, no response is emitted.
